// File: rtl/line_buf_window_4x4.sv
// 4x4 sliding window behind the 4-line SRAM line buffer. Columns from the buffer
// shift in from the right. Column and row counters mark windows that lie fully inside the image.
module line_buf_window_4x4 #(
    parameter int input_size   = 8,
    parameter int line_width   = 114,
    parameter int frame_height = 114
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [input_size-1:0]      in_row1,
    input  logic [input_size-1:0]      in_row2,
    input  logic [input_size-1:0]      in_row3,
    input  logic [input_size-1:0]      in_row4,
    output logic [16*input_size-1:0]   win_data,
    output logic                       win_valid,
    output logic [8:0]                 win_col,
    output logic [8:0]                 win_row,
    output logic                       frame_done
);

    localparam logic [8:0] LAST_COL = 9'(line_width - 1);
    localparam logic [8:0] LAST_ROW = 9'(frame_height - 1);

    logic                  en_d;
    logic [8:0]            col_cnt;
    logic [8:0]            row_cnt;
    logic [input_size-1:0] win [4][4];
    logic                  last_col;
    logic                  last_row;

    assign last_col = (col_cnt == LAST_COL);
    assign last_row = (row_cnt == LAST_ROW);

    // en_d lines up with the buffer's one-cycle read latency, so in_row* is taken only when en_d is high
    always_ff @(posedge clk) begin
        if (rst) begin
            en_d       <= 1'b0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            win_col    <= '0;
            win_row    <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            en_d       <= en;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (en_d) begin
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        win[r][c] <= win[r][c+1];
                    end
                end
                win[0][3]  <= in_row1;
                win[1][3]  <= in_row2;
                win[2][3]  <= in_row3;
                win[3][3]  <= in_row4;
                win_col    <= col_cnt;
                win_row    <= row_cnt;
                win_valid  <= (col_cnt >= 9'd3) && (row_cnt >= 9'd3);
                frame_done <= last_col && last_row;
                if (last_col) begin
                    col_cnt <= '0;
                    row_cnt <= last_row ? 9'd0 : row_cnt + 9'd1;
                end else begin
                    col_cnt <= col_cnt + 9'd1;
                end
            end
        end
    end

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign win_data[((r*4+c)+1)*input_size-1 -: input_size] = win[r][c];
        end
    end

endmodule

// File: tb/tb_line_buf_window_4x4.sv
// Bench for line_buf_window_4x4 on a 6x5 image. A sample-count model gives the expected output
// on every cycle, and literal checks pin the valid/done counts and the first in-image window.
module tb_line_buf_window_4x4;

    localparam int W  = 6;
    localparam int H  = 5;
    localparam int IS = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b1;
    logic [IS-1:0] in_row1 = '0;
    logic [IS-1:0] in_row2 = '0;
    logic [IS-1:0] in_row3 = '0;
    logic [IS-1:0] in_row4 = '0;
    logic [16*IS-1:0] win_data;
    logic          win_valid;
    logic [8:0]    win_col;
    logic [8:0]    win_row;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    line_buf_window_4x4 #(.input_size(IS), .line_width(W), .frame_height(H)) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_row1(in_row1), .in_row2(in_row2), .in_row3(in_row3), .in_row4(in_row4),
        .win_data(win_data), .win_valid(win_valid), .win_col(win_col),
        .win_row(win_row), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: the window is the last four sampled columns, position is the sample count mod line/frame
    logic [31:0]   hist[$];
    logic [31:0]   hcol;
    int            m_n = 0;
    int            m_col, m_row, idx;
    logic          m_en_d = 1'b0;
    bit            started = 1'b0;
    logic [127:0]  exp_data = '0;
    logic          exp_valid = 1'b0;
    logic          exp_done = 1'b0;
    logic [8:0]    exp_col = '0;
    logic [8:0]    exp_row = '0;

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            hist.delete();
            m_n = 0; m_en_d = 1'b0;
            exp_data = '0; exp_valid = 1'b0; exp_done = 1'b0; exp_col = '0; exp_row = '0;
        end else begin
            if (m_en_d) begin
                hist.push_back({in_row4, in_row3, in_row2, in_row1});
                if (hist.size() > 4) void'(hist.pop_front());
                m_col = m_n % W;
                m_row = (m_n / W) % H;
                exp_col   = 9'(m_col);
                exp_row   = 9'(m_row);
                exp_valid = (m_col >= 3) && (m_row >= 3);
                exp_done  = (m_col == W-1) && (m_row == H-1);
                exp_data  = '0;
                for (int c = 0; c < 4; c++) begin
                    idx = hist.size() - 4 + c;
                    if (idx >= 0) begin
                        hcol = hist[idx];
                        for (int r = 0; r < 4; r++) exp_data[(r*4+c)*8 +: 8] = hcol[r*8 +: 8];
                    end
                end
                m_n++;
            end else begin
                exp_valid = 1'b0;
                exp_done  = 1'b0;
            end
            m_en_d = en;
        end
    end

    int         valid_cnt = 0;
    int         done_cnt = 0;
    bit         seen_valid = 1'b0;
    logic [8:0] fv_col, fv_row;
    logic [7:0] fv_d00, fv_d33;

    always @(negedge clk) begin
        if (started) begin
            checkOutput("win_data",   win_data,   exp_data);
            checkOutput("win_valid",  128'(win_valid),  128'(exp_valid));
            checkOutput("win_col",    128'(win_col),    128'(exp_col));
            checkOutput("win_row",    128'(win_row),    128'(exp_row));
            checkOutput("frame_done", 128'(frame_done), 128'(exp_done));
            if (win_valid === 1'b1) begin
                valid_cnt++;
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    fv_col = win_col; fv_row = win_row;
                    fv_d00 = win_data[7:0]; fv_d33 = win_data[127:120];
                end
            end
            if (frame_done === 1'b1) done_cnt++;
        end
    end

    // Driver: data for a column arrives one cycle after its en, tagged {line+r, col}
    int   drv_n = 0;
    logic deliver_next = 1'b0;
    int   dl, dc;

    task automatic applyStimulus(input logic en_v, input logic rst_v);
        @(negedge clk);
        rst = rst_v;
        en  = en_v;
        if (deliver_next) begin
            dl = (drv_n / W) % H;
            dc = drv_n % W;
            in_row1 = {4'(dl + 0), 4'(dc)};
            in_row2 = {4'(dl + 1), 4'(dc)};
            in_row3 = {4'(dl + 2), 4'(dc)};
            in_row4 = {4'(dl + 3), 4'(dc)};
            drv_n++;
        end else begin
            in_row1 = 8'hEE; in_row2 = 8'hEE; in_row3 = 8'hEE; in_row4 = 8'hEE;
        end
        if (rst_v) drv_n = 0;
        deliver_next = en_v && !rst_v;
    endtask

    task automatic clearStats();
        valid_cnt = 0; done_cnt = 0; seen_valid = 1'b0;
    endtask

    task automatic checkFirstWindow(input int exp_valids, input int exp_dones);
        checkOutput("valid_count", 128'(valid_cnt), 128'(exp_valids));
        checkOutput("done_count",  128'(done_cnt),  128'(exp_dones));
        checkOutput("first_valid_col", 128'(fv_col), 128'(9'd3));
        checkOutput("first_valid_row", 128'(fv_row), 128'(9'd3));
        checkOutput("first_valid_d00", 128'(fv_d00), 128'(8'h30));
        checkOutput("first_valid_d33", 128'(fv_d33), 128'(8'h63));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_data"},  win_data, 128'(0));
        checkOutput({tag, "_valid"}, 128'(win_valid), 128'(0));
        checkOutput({tag, "_col"},   128'(win_col), 128'(0));
        checkOutput({tag, "_row"},   128'(win_row), 128'(0));
        checkOutput({tag, "_done"},  128'(frame_done), 128'(0));
    endtask

    initial begin
        // Reset held with en high: everything stays zero
        repeat (3) applyStimulus(1'b1, 1'b1);
        checkAllZero("reset");

        // One continuous frame
        clearStats();
        for (int i = 0; i < W*H; i++) applyStimulus(1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0);
        checkFirstWindow(6, 1);

        // Two frames back to back, each with a 1,0,0,1 gap mid-line
        clearStats();
        for (int i = 0; i < 2*W*H; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (i == 8 || i == 38) repeat (2) applyStimulus(1'b0, 1'b0);
        end
        repeat (4) applyStimulus(1'b0, 1'b0);
        checkFirstWindow(12, 2);

        // Reset at row 2 col 4, then a clean frame from (0,0)
        for (int i = 0; i < 2*W + 5; i++) applyStimulus(1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b1);
        checkAllZero("midrst");
        clearStats();
        for (int i = 0; i < W*H; i++) applyStimulus(1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0);
        checkFirstWindow(6, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
